axilite_master: RTL and testbench
=================================

// Module: axilite_master
// PURPOSE
//  Single-outstanding AXI4-Lite initiator. Converts a simple valid/ready command port (read or write, 32b addr/data) into AXI-Lite channel traffic.
//  Returns the response (rdata, resp code) on a valid/ready response port. Sits between test/control logic and axilite_slave-style responders.
//  Watchdog flags hung transactions.
// PARAMETERS
//  ADDR_W          32    address width (awaddr/araddr/cmd_addr)
//  DATA_W          32    data width (wdata/rdata)
//  TIMEOUT_CYCLES  1024  max wait cycles per AXI phase before timeout_err; 0 disables
// PORTS
//  m_axi_aclk     in   1       clock; all logic on rising edge
//  m_axi_areset   in   1       reset, asynchronous, active-high
//  cmd_valid      in   1       command request
//  cmd_ready      out  1       command accepted when cmd_valid&&cmd_ready
//  cmd_write      in   1       1=write, 0=read
//  cmd_addr       in   ADDR_W  target address
//  cmd_wdata      in   DATA_W  write data (ignored for reads)
//  rsp_valid      out  1       response available
//  rsp_ready      in   1       response consumed when rsp_valid&&rsp_ready
//  rsp_write      out  1       response belongs to a write
//  rsp_rdata      out  DATA_W  read data (0 for writes)
//  rsp_resp       out  2       bresp/rresp as received
//  busy           out  1       state != IDLE
//  timeout_err    out  1       sticky watchdog flag
//  err_clr        in   1       synchronous clear of timeout_err
//  m_axi_awvalid/awready/awaddr   out/in/out  1/1/ADDR_W  write address channel
//  m_axi_wvalid/wready/wdata      out/in/out  1/1/DATA_W  write data channel
//  m_axi_bvalid/bready/bresp      in/out/in   1/1/2       write response channel
//  m_axi_arvalid/arready/araddr   out/in/out  1/1/ADDR_W  read address channel
//  m_axi_rvalid/rready/rdata/rresp in/out/in/in 1/1/DATA_W/2 read data channel
// BEHAVIOUR
//  Reset: every output 0, state IDLE, watchdog counter 0. Async assert: valids/readies drop immediately; in-flight txn and pending rsp are discarded.
//  cmd_ready = (state==IDLE) && !m_axi_areset (combinational); busy registered.
//  FSM: IDLE -> WR_AW_W | RD_AR; WR_AW_W -> WR_B -> RSP; RD_AR -> RD_R -> RSP; RSP -> IDLE.
//  IDLE: on cmd handshake latch addr/wdata/write; next cycle assert awvalid+wvalid (write) or arvalid (read).
//  WR_AW_W: awvalid held until edge with awvalid&&awready, then 0; same independently for wvalid/wready.
//   Addr and data stay stable while valid is high. Both accepted (same or different cycles) -> WR_B, bready=1 next cycle.
//   A ready seen while the matching valid is low is not a handshake. The slave may take W several cycles after AW.
//  WR_B: bready held until edge with bvalid&&bready; capture bresp; bready<=0; rsp_rdata<=0.
//  RD_AR: arvalid held to arready handshake -> RD_R, rready=1. RD_R: capture rdata/rresp on rvalid&&rready; rready<=0.
//  RSP: rsp_valid=1, outputs stable until rsp_ready; handshake -> IDLE (rsp_valid 0 next cycle). Min write cmd-to-rsp_valid: 4 cycles with zero-wait slave.
//  Only one txn outstanding; cmd_valid while busy is ignored (no queuing). rresp/bresp passed through unmodified (2'b11 included).
//  Watchdog: counter clears on each state change. It counts every cycle in WR_AW_W/WR_B/RD_AR/RD_R.
//   At count==TIMEOUT_CYCLES-1 set timeout_err. Txn is NOT aborted (protocol-legal); the counter saturates.
//  err_clr and a new timeout in the same cycle: set wins.
//  Width: counter $clog2(TIMEOUT_CYCLES+1) bits; addresses passed through without truncation.
// STRUCTURE
//  axilite_pkg: resp localparams OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11; master FSM state enum (typedef logic[2:0]).
//  axilite_pkg is shared with axilite_slave.
//  One sub-module natural: axilite_wdog (counter+sticky flag; ports clk, rst, run, restart, clr, expired).
// TESTING (bench pairs DUT with axilite_slave, inverted reset)
//  1 write 0x05/0xDEADBEEF then read 0x05 -> bresp 00, rsp_rdata 0xDEADBEEF, rresp 00
//  2 write addr 200 -> rsp_resp 2'b11; read addr 130 -> rsp_resp 2'b11, rsp_rdata 0
//  3 stub slave delays wready 5 cycles after awready -> wvalid held 6 cycles, wdata stable, single bready handshake
//  4 hold rsp_ready=0 for 3 cycles -> rsp_valid/data stable, cmd_ready=0, following cmd accepted after release
//  5 TIMEOUT_CYCLES=16, stub never asserts bvalid -> timeout_err=1 after 16 cycles in WR_B, bready still 1; err_clr -> 0
//  6 async reset mid RD_R -> arvalid/rready/rsp_valid 0 same cycle, no rsp emitted; next read completes normally

Source files
------------

// File: rtl/axilite_pkg.sv
// Shared AXI4-Lite definitions: response codes and master FSM encoding.
// Used by the initiator and by slave-side responders.
package axilite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR_AW_W = 3'd1;
  localparam state_t ST_WR_B    = 3'd2;
  localparam state_t ST_RD_AR   = 3'd3;
  localparam state_t ST_RD_R    = 3'd4;
  localparam state_t ST_RSP     = 3'd5;

  // States that wait on the slave and are therefore watched.
  function automatic logic in_axi_phase(state_t s);
    return (s == ST_WR_AW_W) || (s == ST_WR_B) ||
           (s == ST_RD_AR)   || (s == ST_RD_R);
  endfunction

endpackage

// File: rtl/axilite_if.sv
// AXI4-Lite channel bundle with master/slave views.
// Five independent valid/ready channels.
interface axilite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;

  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;

  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr,
    output wvalid, wdata,
    output bready,
    output arvalid, araddr,
    output rready,
    input  awready, wready,
    input  bvalid, bresp,
    input  arready,
    input  rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr,
    input  wvalid, wdata,
    input  bready,
    input  arvalid, araddr,
    input  rready,
    output awready, wready,
    output bvalid, bresp,
    output arready,
    output rvalid, rdata, rresp
  );

endinterface

// File: rtl/axilite_wdog.sv
// Phase watchdog: saturating cycle counter plus sticky expiry flag.
// A set in the same cycle as clr takes priority.
module axilite_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned LAST_I =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(LAST_I);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic          EN   = (TIMEOUT_CYCLES > 0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          hit;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (run && (cnt_q != SAT)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  assign hit = EN && run && (cnt_q == LAST);

  always_comb begin
    err_d = err_q;
    if (hit) begin
      err_d = 1'b1;
    end else if (clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign expired = err_q;

endmodule

// File: rtl/axilite_master.sv
// Single-outstanding AXI4-Lite initiator driven by a cmd/rsp port.
// Watchdog flags phases where the slave stalls too long.
module axilite_master
  import axilite_pkg::*;
#(
  parameter int          ADDR_W         = 32,
  parameter int          DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              m_axi_aclk,
  input  logic              m_axi_areset,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,

  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr,

  axilite_if.master         m_axi
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;
  logic              busy_q, busy_d;

  logic aw_done;
  logic w_done;
  logic wd_run;
  logic wd_restart;

  // A channel is done once its valid has dropped or handshakes now.
  assign aw_done = !awvalid_q || m_axi.awready;
  assign w_done  = !wvalid_q  || m_axi.wready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          write_d = cmd_write;
          if (cmd_write) begin
            state_d   = ST_WR_AW_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end

      ST_WR_AW_W: begin
        if (awvalid_q && m_axi.awready) begin
          awvalid_d = 1'b0;
        end
        if (wvalid_q && m_axi.wready) begin
          wvalid_d = 1'b0;
        end
        if (aw_done && w_done) begin
          state_d  = ST_WR_B;
          bready_d = 1'b1;
        end
      end

      ST_WR_B: begin
        if (m_axi.bvalid) begin
          state_d  = ST_RSP;
          bready_d = 1'b0;
          resp_d   = m_axi.bresp;
          rdata_d  = '0;
        end
      end

      ST_RD_AR: begin
        if (m_axi.arready) begin
          state_d   = ST_RD_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end

      ST_RD_R: begin
        if (m_axi.rvalid) begin
          state_d  = ST_RSP;
          rready_d = 1'b0;
          rdata_d  = m_axi.rdata;
          resp_d   = m_axi.rresp;
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      busy_q    <= busy_d;
    end
  end

  assign wd_run     = in_axi_phase(state_q);
  assign wd_restart = (state_d != state_q);

  axilite_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (m_axi_aclk),
    .rst     (m_axi_areset),
    .run     (wd_run),
    .restart (wd_restart),
    .clr     (err_clr),
    .expired (timeout_err)
  );

  assign cmd_ready = (state_q == ST_IDLE) && !m_axi_areset;
  assign busy      = busy_q;

  assign rsp_valid = (state_q == ST_RSP);
  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

  assign m_axi.awvalid = awvalid_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axilite_master.sv
// Directed bench for axilite_master against a behavioural AXI-Lite slave.
// Slave decodes 0..127 as RAM, anything higher as DECERR.
module tb_axilite_master;
  import axilite_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          busy;
  logic          timeout_err;
  logic          err_clr = 1'b0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  axilite_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axilite_master #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .m_axi_aclk   (clk),
    .m_axi_areset (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_write    (rsp_write),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr),
    .m_axi        (bus)
  );

  // ---------------- behavioural slave ----------------
  int          wdelay = 0;
  logic        b_never = 1'b0;
  logic        r_stall = 1'b0;
  logic        aw_got, w_got, bpend, rpend;
  int          wcnt;
  logic [31:0] waddr_l, wdata_l, last_awaddr;
  logic [31:0] rdata_l;
  logic [1:0]  bresp_l, rresp_l;
  logic [31:0] mem [0:127];

  wire aw_hs = bus.awvalid && bus.awready;
  wire w_hs  = bus.wvalid && bus.wready;
  wire ar_hs = bus.arvalid && bus.arready;
  wire b_hs  = bus.bvalid && bus.bready;
  wire r_hs  = bus.rvalid && bus.rready;
  wire [31:0] wr_addr = aw_hs ? bus.awaddr : waddr_l;
  wire [31:0] wr_data = w_hs ? bus.wdata : wdata_l;
  wire wr_fire = (aw_got || aw_hs) && (w_got || w_hs);

  assign bus.awready = 1'b1;
  assign bus.arready = 1'b1;
  assign bus.wready  = (wdelay == 0) || (aw_got && (wcnt >= wdelay - 1));
  assign bus.bvalid  = bpend && !b_never;
  assign bus.bresp   = bresp_l;
  assign bus.rvalid  = rpend && !r_stall;
  assign bus.rdata   = rdata_l;
  assign bus.rresp   = rresp_l;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0;
      bpend <= 1'b0; rpend <= 1'b0;
      wcnt <= 0;
      waddr_l <= '0; wdata_l <= '0;
      last_awaddr <= '0;
      rdata_l <= '0; bresp_l <= OKAY; rresp_l <= OKAY;
    end else begin
      if (aw_hs) begin
        waddr_l <= bus.awaddr;
        last_awaddr <= bus.awaddr;
      end
      if (w_hs) wdata_l <= bus.wdata;
      if (wr_fire) begin
        aw_got <= 1'b0; w_got <= 1'b0; wcnt <= 0;
        bpend <= 1'b1;
        bresp_l <= (wr_addr < 128) ? OKAY : DECERR;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs) w_got <= 1'b1;
        if (aw_got) wcnt <= wcnt + 1;
      end
      if (b_hs) bpend <= 1'b0;
      if (ar_hs) begin
        rpend <= 1'b1;
        rdata_l <= (bus.araddr < 128) ? mem[bus.araddr[6:0]] : 32'h0;
        rresp_l <= (bus.araddr < 128) ? OKAY : DECERR;
      end
      if (r_hs) rpend <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst && wr_fire && (wr_addr < 128)) mem[wr_addr[6:0]] <= wr_data;
  end

  // ---------------- bus monitor ----------------
  int          wv_cnt = 0;
  int          wd_unstable = 0;
  int          b_hs_cnt = 0;
  logic        wv_prev = 1'b0;
  logic [31:0] wd_prev = '0;

  always @(posedge clk) begin
    if (bus.wvalid) wv_cnt <= wv_cnt + 1;
    if (bus.wvalid && wv_prev && (bus.wdata != wd_prev))
      wd_unstable <= wd_unstable + 1;
    if (b_hs) b_hs_cnt <= b_hs_cnt + 1;
    wv_prev <= bus.wvalid;
    wd_prev <= bus.wdata;
  end

  // Drives one command and consumes its response immediately; no checks.
  task automatic run_txn(input logic w, input logic [31:0] a,
                         input logic [31:0] d, output logic ok,
                         output logic rw, output logic [31:0] rd,
                         output logic [1:0] rs);
    int n;
    ok = 1'b0; rw = 1'b0; rd = '0; rs = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk); n++;
    end
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 200) begin
      @(negedge clk); n++;
    end
    if (!rsp_valid) return;
    rw = rsp_write; rd = rsp_rdata; rs = rsp_resp;
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else passed++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); else passed++;
    checks++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout got=%b exp=0", timeout_err); else passed++;
    checks++; if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0)
      $display("FAIL rst_axi_ctrl got=%b exp=00000",
               {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
    else passed++;
    checks++; if (rsp_rdata !== 32'h0) $display("FAIL rst_rdata got=%h exp=0", rsp_rdata); else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) $display("FAIL idle_cmd_ready got=%b exp=1", cmd_ready); else passed++;
  endtask

  task automatic test_write_read();
    logic ok, rw; logic [31:0] rd; logic [1:0] rs;
    run_txn(1'b1, 32'h5, 32'hDEADBEEF, ok, rw, rd, rs);
    checks++; if (ok !== 1'b1) $display("FAIL wr5_done got=%b exp=1", ok); else passed++;
    checks++; if (rw !== 1'b1) $display("FAIL wr5_rsp_write got=%b exp=1", rw); else passed++;
    checks++; if (rs !== OKAY) $display("FAIL wr5_bresp got=%b exp=00", rs); else passed++;
    checks++; if (rd !== 32'h0) $display("FAIL wr5_rdata got=%h exp=0", rd); else passed++;
    checks++; if (last_awaddr !== 32'h5) $display("FAIL wr5_awaddr got=%h exp=5", last_awaddr); else passed++;
    run_txn(1'b0, 32'h5, 32'h0, ok, rw, rd, rs);
    checks++; if (ok !== 1'b1) $display("FAIL rd5_done got=%b exp=1", ok); else passed++;
    checks++; if (rw !== 1'b0) $display("FAIL rd5_rsp_write got=%b exp=0", rw); else passed++;
    checks++; if (rd !== 32'hDEADBEEF) $display("FAIL rd5_rdata got=%h exp=deadbeef", rd); else passed++;
    checks++; if (rs !== OKAY) $display("FAIL rd5_rresp got=%b exp=00", rs); else passed++;
  endtask

  task automatic test_decerr();
    logic ok, rw; logic [31:0] rd; logic [1:0] rs;
    run_txn(1'b1, 32'd200, 32'h11112222, ok, rw, rd, rs);
    checks++; if (ok !== 1'b1) $display("FAIL wr200_done got=%b exp=1", ok); else passed++;
    checks++; if (rs !== 2'b11) $display("FAIL wr200_bresp got=%b exp=11", rs); else passed++;
    run_txn(1'b0, 32'd130, 32'h0, ok, rw, rd, rs);
    checks++; if (ok !== 1'b1) $display("FAIL rd130_done got=%b exp=1", ok); else passed++;
    checks++; if (rs !== 2'b11) $display("FAIL rd130_rresp got=%b exp=11", rs); else passed++;
    checks++; if (rd !== 32'h0) $display("FAIL rd130_rdata got=%h exp=0", rd); else passed++;
  endtask

  task automatic test_wready_delay();
    logic ok, rw; logic [31:0] rd; logic [1:0] rs;
    int wv0, un0, b0;
    wv0 = wv_cnt; un0 = wd_unstable; b0 = b_hs_cnt;
    wdelay = 5;
    run_txn(1'b1, 32'h10, 32'h12345678, ok, rw, rd, rs);
    wdelay = 0;
    checks++; if (ok !== 1'b1) $display("FAIL wdly_done got=%b exp=1", ok); else passed++;
    checks++; if (wv_cnt - wv0 != 6) $display("FAIL wdly_wvalid_cycles got=%0d exp=6", wv_cnt - wv0); else passed++;
    checks++; if (wd_unstable - un0 != 0) $display("FAIL wdly_wdata_stable got=%0d exp=0", wd_unstable - un0); else passed++;
    checks++; if (b_hs_cnt - b0 != 1) $display("FAIL wdly_b_handshakes got=%0d exp=1", b_hs_cnt - b0); else passed++;
    checks++; if (rs !== OKAY) $display("FAIL wdly_bresp got=%b exp=00", rs); else passed++;
    checks++; if (timeout_err !== 1'b0) $display("FAIL wdly_no_timeout got=%b exp=0", timeout_err); else passed++;
    run_txn(1'b0, 32'h10, 32'h0, ok, rw, rd, rs);
    checks++; if (rd !== 32'h12345678) $display("FAIL wdly_readback got=%h exp=12345678", rd); else passed++;
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h5;
    @(posedge clk); #1;
    cmd_addr = 32'h10;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      @(negedge clk); n++;
    end
    checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_rsp_arrive got=%b exp=1", rsp_valid); else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_hold_valid_%0d got=%b exp=1", i, rsp_valid); else passed++;
      checks++; if (rsp_rdata !== 32'hDEADBEEF) $display("FAIL bp_hold_rdata_%0d got=%h exp=deadbeef", i, rsp_rdata); else passed++;
      checks++; if (cmd_ready !== 1'b0) $display("FAIL bp_cmd_ready_%0d got=%b exp=0", i, cmd_ready); else passed++;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_rsp_drop got=%b exp=0", rsp_valid); else passed++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL bp_idle_ready got=%b exp=1", cmd_ready); else passed++;
    @(posedge clk); #1 cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL bp_next_accepted got=%b exp=1", busy); else passed++;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      @(negedge clk); n++;
    end
    checks++; if (rsp_rdata !== 32'h12345678) $display("FAIL bp_next_rdata got=%h exp=12345678", rsp_rdata); else passed++;
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    b_never = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h55;
    @(posedge clk); #1 cmd_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.bready && n < 20) begin
      @(negedge clk); n++;
    end
    checks++; if (bus.bready !== 1'b1) $display("FAIL to_reach_wr_b got=%b exp=1", bus.bready); else passed++;
    repeat (15) @(negedge clk);
    checks++; if (timeout_err !== 1'b0) $display("FAIL to_early got=%b exp=0", timeout_err); else passed++;
    @(negedge clk);
    checks++; if (timeout_err !== 1'b1) $display("FAIL to_set got=%b exp=1", timeout_err); else passed++;
    checks++; if (bus.bready !== 1'b1) $display("FAIL to_bready_held got=%b exp=1", bus.bready); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL to_not_aborted got=%b exp=1", busy); else passed++;
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    checks++; if (timeout_err !== 1'b0) $display("FAIL to_clear got=%b exp=0", timeout_err); else passed++;
    repeat (5) @(negedge clk);
    checks++; if (timeout_err !== 1'b0) $display("FAIL to_saturated got=%b exp=0", timeout_err); else passed++;
    b_never = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk); n++;
    end
    checks++; if ({rsp_valid, rsp_write, rsp_resp} !== {1'b1, 1'b1, OKAY})
      $display("FAIL to_late_rsp got=%b exp=1100", {rsp_valid, rsp_write, rsp_resp});
    else passed++;
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    logic ok, rw; logic [31:0] rd; logic [1:0] rs;
    int n;
    r_stall = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h5;
    @(posedge clk); #1 cmd_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.rready && n < 20) begin
      @(negedge clk); n++;
    end
    checks++; if (bus.rready !== 1'b1) $display("FAIL ar_reach_rd_r got=%b exp=1", bus.rready); else passed++;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    checks++; if ({bus.arvalid, bus.rready, rsp_valid, busy, cmd_ready} !== 5'b0)
      $display("FAIL ar_async_drop got=%b exp=00000",
               {bus.arvalid, bus.rready, rsp_valid, busy, cmd_ready});
    else passed++;
    r_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL ar_no_rsp got=%b exp=00", {rsp_valid, busy}); else passed++;
    run_txn(1'b0, 32'h5, 32'h0, ok, rw, rd, rs);
    checks++; if (ok !== 1'b1) $display("FAIL ar_recover_done got=%b exp=1", ok); else passed++;
    checks++; if (rd !== 32'hDEADBEEF) $display("FAIL ar_recover_rdata got=%h exp=deadbeef", rd); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_decerr();
    test_wready_delay();
    test_backpressure();
    test_timeout();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
